// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - instruction sequencer: fetch/decode/execute/writeback control FSM
module seq_ctrl #(
    parameter int             NS      = 7,
    parameter logic [NS:0]    LAST_PC = 8'h7E
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   instr,
    input  logic          alu_done,
    output logic [NS:0]   pc,
    output logic [3:0]    ra,
    output logic [3:0]    rb,
    output logic [3:0]    wa,
    output logic [3:0]    alu_op,
    output logic [7:0]    imm,
    output logic          imm_sel,
    output logic          alu_start,
    output logic          reg_we,
    output logic          busy,
    output logic          halted,
    output logic          illegal
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        WB2    = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t       state;
    state_t       next;
    logic [15:0]  ir;
    logic         illegal_q;
    logic         exec_busy;

    function automatic logic is_legal(input logic [15:0] w);
        case (w[15:12])
            4'hF:       is_legal = (w[3:0] inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h7, 4'h8});
            4'h8, 4'h9: is_legal = 1'b1;
            default:    is_legal = 1'b0;
        endcase
    endfunction

    logic ir_rtype;
    logic ir_muldiv;
    logic ir_swp;

    assign ir_rtype  = (ir[15:12] == 4'hF) && is_legal(ir);
    assign ir_muldiv = ir_rtype && ((ir[3:0] == 4'h4) || (ir[3:0] == 4'h5));
    assign ir_swp    = ir_rtype && (ir[3:0] == 4'h8);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = FETCH;
            FETCH:   next = DECODE;
            // A zero word is a clean stop; anything undecodable stops with the illegal flag.
            DECODE:  next = ((instr == 16'h0000) || !is_legal(instr)) ? HALT : EXEC;
            EXEC:    if (!ir_muldiv || alu_done) next = WB;
            WB:      next = ir_swp ? WB2 : ((pc == LAST_PC) ? HALT : FETCH);
            WB2:     next = (pc == LAST_PC) ? HALT : FETCH;
            HALT:    if (start) next = FETCH;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc        <= '0;
            ir        <= '0;
            illegal_q <= 1'b0;
            exec_busy <= 1'b0;
        end else begin
            // exec_busy marks the second and later EXEC cycles so alu_start fires once.
            exec_busy <= (state == EXEC) && (next == EXEC);
            if (((state == IDLE) || (state == HALT)) && start) begin
                pc        <= '0;
                illegal_q <= 1'b0;
            end
            if (state == DECODE) begin
                ir <= instr;
                if ((instr != 16'h0000) && !is_legal(instr)) begin
                    illegal_q <= 1'b1;
                end
            end
            if (((state == WB) || (state == WB2)) && (next == FETCH)) begin
                pc <= pc + (NS+1)'(2);
            end
        end
    end

    always_comb begin
        ra        = 4'h0;
        rb        = 4'h0;
        wa        = 4'h0;
        alu_op    = 4'h0;
        imm       = 8'h00;
        imm_sel   = 1'b0;
        case (ir[15:12])
            4'hF: begin
                if (ir_rtype) begin
                    ra     = ir[11:8];
                    rb     = ir[7:4];
                    wa     = ir[11:8];
                    alu_op = ir[3:0];
                end
            end
            4'h8: begin
                ra      = ir[11:8];
                wa      = ir[11:8];
                alu_op  = 4'h2;
                imm     = ir[7:0];
                imm_sel = 1'b1;
            end
            4'h9: begin
                ra      = ir[11:8];
                wa      = ir[11:8];
                alu_op  = 4'h3;
                imm     = ir[7:0];
                imm_sel = 1'b1;
            end
            default: ;
        endcase
        // Second half of a swap writes the captured A operand into the rb register.
        if (state == WB2) begin
            wa     = ir[7:4];
            alu_op = 4'h9;
        end
        alu_start = (state == EXEC) && !exec_busy;
        reg_we    = (state == WB) || (state == WB2);
        busy      = (state == FETCH) || (state == DECODE) || (state == EXEC) ||
                    (state == WB) || (state == WB2);
        halted    = (state == HALT);
        illegal   = illegal_q;
    end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter NS, default 7; PC width is NS+1 bits.
REQ-002 SHALL have parameter LAST_PC, default 8'h7E; this is the last legal fetch address.
REQ-003 SHALL have port clk, input, 1 bit; single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit; asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit; begins execution at PC 0 from IDLE or HALT.
REQ-006 SHALL have port instr, input, 16 bits; registered instruction-memory word, valid one cycle after pc.
REQ-007 SHALL have port alu_done, input, 1 bit; completion of a multi-cycle ALU op (MUL/DIV).
REQ-008 SHALL have port pc, output, NS+1 bits; byte address to instruction memory, always even.
REQ-009 SHALL have ports ra, rb and wa, each output, 4 bits; register-file read A, read B and write addresses.
REQ-010 SHALL have port alu_op, output, 4 bits; datapath operation select.
REQ-011 SHALL have port imm, output, 8 bits; immediate field.
REQ-012 SHALL have port imm_sel, output, 1 bit; 1 selects imm as operand B.
REQ-013 SHALL have port alu_start, output, 1 bit; one-cycle pulse; datapath captures operands on it.
REQ-014 SHALL have port reg_we, output, 1 bit; one-cycle register write strobe.
REQ-015 SHALL have ports busy, halted and illegal, each output, 1 bit; status flags.

Function
REQ-016 SHALL implement states IDLE, FETCH, DECODE, EXEC, WB, WB2, HALT.
REQ-017 IDLE->FETCH SHALL occur on start=1, with pc<=0; start SHALL be ignored in FETCH through WB2.
REQ-018 FETCH SHALL last 1 cycle with pc stable, then go to DECODE.
REQ-019 DECODE SHALL latch instr into the internal IR in 1 cycle, then go to EXEC.
REQ-020 Decode rules SHALL be:
- IR[15:12]=F: ra=IR[11:8], rb=IR[7:4], wa=IR[11:8], alu_op=IR[3:0], imm_sel=0.
- IR[15:12]=8 (ANDI): alu_op=2, ra=wa=IR[11:8], imm=IR[7:0], imm_sel=1.
- IR[15:12]=9 (ORI): alu_op=3, ra=wa=IR[11:8], imm=IR[7:0], imm_sel=1.
REQ-021 Legal R-type func values SHALL be 0 ADD, 1 SUB, 4 MUL, 5 DIV, 7 MOV, 8 SWP.
REQ-022 Any other func or opcode SHALL set illegal=1 and go to HALT with no alu_start and no reg_we.
REQ-023 IR=16'h0000 SHALL go to HALT with illegal=0.
REQ-024 EXEC SHALL pulse alu_start on its first cycle.
REQ-025 For MUL/DIV, EXEC SHALL hold until alu_done=1, then go to WB; alu_done SHALL be ignored in all other states.
REQ-026 For all other legal ops, EXEC SHALL last 1 cycle.
REQ-027 WB SHALL pulse reg_we with wa=IR[11:8].
REQ-028 After WB, SWP SHALL go to WB2; every other op SHALL advance pc.
REQ-029 WB2 (SWP only) SHALL pulse reg_we with wa=IR[7:4] and alu_op=4'h9 (pass captured A).
REQ-030 After WB or WB2: if pc==LAST_PC, go to HALT with pc unchanged; else pc<=pc+2 and go to FETCH.
REQ-031 Cycles per instruction SHALL be: 4 for single-cycle ops, 5 for SWP, 3+N for MUL/DIV, where N is the number of alu_done wait cycles (minimum 1).
REQ-032 pc bit 0 SHALL always be 0; pc SHALL never wrap past LAST_PC.
REQ-033 busy SHALL be 1 in FETCH through WB2 and 0 otherwise.
REQ-034 halted SHALL be 1 only in HALT.
REQ-035 start in HALT SHALL clear illegal, set pc<=0 and go to FETCH.

Reset
REQ-036 rst=0 SHALL asynchronously force state=IDLE, IR=0, pc=0, ra=rb=wa=0, alu_op=0, imm=0, imm_sel=0, alu_start=0, reg_we=0, busy=0, halted=0 and illegal=0.
REQ-037 Reset mid-instruction, including during a MUL/DIV wait, SHALL abort without any reg_we pulse.
REQ-038 After rst returns high, seq_ctrl SHALL remain in IDLE until start.

Verification
REQ-039 Program F120 (ADD R1 R2) then 0000; start -> ra=1, rb=2, alu_op=0, alu_start pulse in cycle 3, reg_we with wa=1 in cycle 4, pc=2, then halted=1, illegal=0.
REQ-040 93FF (ORI R3 FF) -> imm_sel=1, imm=8'hFF, alu_op=3, wa=3, 4-cycle instruction.
REQ-041 F564 (MUL R5 R6) with alu_done delayed 5 cycles -> alu_start pulses once, reg_we only after alu_done, pc advances by 2.
REQ-042 F468 (SWP R4 R6) -> two reg_we pulses on consecutive cycles: wa=4, then wa=6 with alu_op=9.
REQ-043 F123 (illegal func) -> illegal=1, halted=1, no reg_we; a following start -> pc=0 and illegal=0.
REQ-044 rst=0 asserted during the MUL wait -> all outputs zero immediately; a 64-word program with no 0000 word -> halts at pc=8'h7E after 64 instructions.
